// File: rtl/mux_pkg.sv
// Shared widths and state encoding for the 16:1 serializer path.
// Both the mux and the serializer import this package.
package mux_pkg;

   localparam int WORD_W = 16;
   localparam int SEL_W  = 4;

   localparam logic [SEL_W-1:0] CNT_MAX = SEL_W'(WORD_W - 1);

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_SHIFT = 1'b1;

endpackage

// File: rtl/mux_16x1.sv
// Combinational 16:1 bit select. It is fed only from registers, so its
// output changes only at clock edges.
module mux_16x1
   import mux_pkg::*;
(
   output logic              out,
   input  logic [WORD_W-1:0] i,
   input  logic [SEL_W-1:0]  s
);

   assign out = i[s];

endmodule

// File: rtl/mux_serializer_16.sv
// Parallel-to-serial front end: takes a 16-bit word on valid/ready and
// streams it out one bit per beat through mux_16x1.
//
// state    | meaning
// ---------+--------------------------------------------------------
// ST_IDLE  | no word held; load_ready=1, ser_valid=0
// ST_SHIFT | word in flight; ser_valid=1, cnt = beats already sent
module mux_serializer_16
   import mux_pkg::*;
#(
   parameter bit LSB_FIRST  = 1'b1,
   parameter bit IDLE_LEVEL = 1'b0
)
(
   input  logic              clk,
   input  logic              rst,
   input  logic              load_valid,
   output logic              load_ready,
   input  logic [WORD_W-1:0] i,
   input  logic              ser_ready,
   output logic              ser_valid,
   output logic              ser_out,
   output logic [SEL_W-1:0]  s,
   output logic              last,
   output logic              busy
);

   logic [0:0]        state;
   logic [0:0]        state_nxt;
   logic [SEL_W-1:0]  cnt;
   logic [SEL_W-1:0]  cnt_nxt;
   logic [WORD_W-1:0] data_reg;
   logic [WORD_W-1:0] data_nxt;
   logic              in_shift;
   logic              beat;
   logic              take;
   logic              mux_out;

   assign in_shift   = (state == ST_SHIFT);
   assign ser_valid  = in_shift;
   assign busy       = in_shift;
   assign last       = in_shift && (cnt == CNT_MAX);
   // Final beat frees the register in the same cycle, so words can abut.
   assign load_ready = !in_shift || (last && ser_ready);
   assign beat       = in_shift && ser_ready;
   assign take       = load_valid && load_ready;

   assign s       = LSB_FIRST ? cnt : (CNT_MAX - cnt);
   assign ser_out = ser_valid ? mux_out : IDLE_LEVEL;

   mux_16x1 u_mux (
      .out (mux_out),
      .i   (data_reg),
      .s   (s)
   );

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      data_nxt  = data_reg;
      case (state)
         ST_IDLE: begin
            if (take) begin
               data_nxt  = i;
               cnt_nxt   = '0;
               state_nxt = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (beat) begin
               if (!last) begin
                  cnt_nxt = cnt + SEL_W'(1);
               end else if (take) begin
                  data_nxt = i;
                  cnt_nxt  = '0;
               end else begin
                  cnt_nxt   = '0;
                  state_nxt = ST_IDLE;
               end
            end
         end
         default: begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         cnt      <= '0;
         data_reg <= '0;
      end else begin
         state    <= state_nxt;
         cnt      <= cnt_nxt;
         data_reg <= data_nxt;
      end
   end

endmodule

// File: tb/tb_mux_serializer_16.sv
// Bench for mux_serializer_16: one LSB-first and one MSB-first instance on
// shared stimulus, checked against a beat-level model and a bit-stream queue.
module tb_mux_serializer_16;

   logic        clk;
   logic        rst;
   logic        load_valid;
   logic [15:0] i;
   logic        ser_ready;

   logic [1:0]  lr;
   logic [1:0]  sv;
   logic [1:0]  so;
   logic [1:0]  lst;
   logic [1:0]  bsy;
   logic [3:0]  ss [2];

   int errors;
   int checks;

   mux_serializer_16 #(.LSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut_lsb (
      .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(lr[0]),
      .i(i), .ser_ready(ser_ready), .ser_valid(sv[0]), .ser_out(so[0]),
      .s(ss[0]), .last(lst[0]), .busy(bsy[0])
   );

   mux_serializer_16 #(.LSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) dut_msb (
      .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(lr[1]),
      .i(i), .ser_ready(ser_ready), .ser_valid(sv[1]), .ser_out(so[1]),
      .s(ss[1]), .last(lst[1]), .busy(bsy[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   // Model: per instance, whether a word is held, the word, and how many of
   // its bits have been accepted downstream. Bit order follows from position.
   logic        m_busy [2];
   logic [15:0] m_word [2];
   int          m_done [2];
   logic        q_bits [2][$];
   bit          en;

   initial begin
      en = 1'b0;
      for (int k = 0; k < 2; k++) begin
         m_busy[k] = 1'b0;
         m_word[k] = '0;
         m_done[k] = 0;
      end
   end

   always @(negedge clk) begin
      for (int k = 0; k < 2; k++) begin
         int   pos;
         logic e_last;
         logic e_lr;
         logic e_out;
         logic mbeat;
         logic mtake;
         pos    = (k == 0) ? m_done[k] : 15 - m_done[k];
         e_last = m_busy[k] && (m_done[k] == 15);
         e_lr   = !m_busy[k] || (e_last && ser_ready);
         e_out  = m_busy[k] ? m_word[k][pos] : 1'b0;
         if (en) begin
            check($sformatf("ser_valid[%0d]", k), 32'(sv[k]), 32'(m_busy[k]));
            check($sformatf("busy[%0d]", k), 32'(bsy[k]), 32'(m_busy[k]));
            check($sformatf("last[%0d]", k), 32'(lst[k]), 32'(e_last));
            check($sformatf("load_ready[%0d]", k), 32'(lr[k]), 32'(e_lr));
            check($sformatf("s[%0d]", k), 32'(ss[k]), 32'(pos));
            check($sformatf("ser_out[%0d]", k), 32'(so[k]), 32'(e_out));
         end
         mbeat = m_busy[k] && ser_ready;
         mtake = load_valid && e_lr;
         if (en && mbeat && !rst) begin
            if (q_bits[k].size() == 0) begin
               check($sformatf("stream_underflow[%0d]", k), 32'(q_bits[k].size()), 32'd1);
            end else begin
               logic eb;
               eb = q_bits[k].pop_front();
               check($sformatf("stream_bit[%0d]", k), 32'(so[k]), 32'(eb));
            end
         end
         if (rst) begin
            m_busy[k] = 1'b0;
            m_done[k] = 0;
            m_word[k] = '0;
            q_bits[k].delete();
         end else begin
            if (mbeat) begin
               m_done[k]++;
               if (m_done[k] == 16) begin
                  m_busy[k] = 1'b0;
                  m_done[k] = 0;
               end
            end
            if (mtake) begin
               m_busy[k] = 1'b1;
               m_word[k] = i;
               m_done[k] = 0;
               for (int b = 0; b < 16; b++)
                  q_bits[k].push_back(i[(k == 0) ? b : 15 - b]);
            end
         end
      end
      if (rst) en = 1'b1;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Load one word, then drive ser_ready/rst/load_valid per the options and
   // capture the bits each instance emits, in beat order.
   task automatic xfer(input logic [15:0] w, input int stall_at, input int rst_at,
                       input int pulse_at, output logic [15:0] c0,
                       output logic [15:0] c1, output int cycles);
      int n;
      int held;
      int guard;
      c0 = '0; c1 = '0; n = 0; held = 0; cycles = 0; guard = 0;
      load_valid = 1'b1;
      i = w;
      @(negedge clk);
      while (!lr[0] && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      check("load_accept", 32'(lr[0]), 32'd1);
      step();
      load_valid = 1'b0;
      while (n < 16 && cycles < 64) begin
         ser_ready = !(n == stall_at && held < 3);
         if (!ser_ready) held++;
         load_valid = (n == pulse_at);
         i = load_valid ? 16'hBEEF : w;
         rst = (n == rst_at);
         @(negedge clk);
         if (!ser_ready) begin
            check("stall_s_lsb", 32'(ss[0]), 32'(stall_at));
            check("stall_s_msb", 32'(ss[1]), 32'(15 - stall_at));
            check("stall_out_lsb", 32'(so[0]), 32'(w[stall_at]));
            check("stall_out_msb", 32'(so[1]), 32'(w[15 - stall_at]));
         end
         if (sv[0] && ser_ready) begin
            c0[n] = so[0];
            c1[n] = so[1];
            n++;
         end
         cycles++;
         step();
         if (rst) begin
            rst = 1'b0;
            break;
         end
      end
      load_valid = 1'b0;
      ser_ready = 1'b1;
      if (rst_at < 0) check("beats_done", 32'(n), 32'd16);
   endtask

   initial begin
      logic [15:0] c0, c1;
      logic [31:0] b0, b1;
      int cyc, n, guard;
      errors = 0;
      checks = 0;
      rst = 1'b1;
      load_valid = 1'b0;
      i = '0;
      ser_ready = 1'b1;
      step();
      step();
      rst = 1'b0;
      @(negedge clk);
      check("rst_valid", 32'(sv), 32'd0);
      check("rst_ready", 32'(lr), 32'd3);
      check("rst_s_lsb", 32'(ss[0]), 32'd0);
      check("rst_s_msb", 32'(ss[1]), 32'd15);
      check("rst_out", 32'(so), 32'd0);
      step();

      // Single-bit word: order of emission differs per instance.
      xfer(16'h0001, -1, -1, -1, c0, c1, cyc);
      check("w0001_lsb", 32'(c0), 32'h0001);
      check("w0001_msb", 32'(c1), 32'h8000);
      check("w0001_cycles", 32'(cyc), 32'd16);
      @(negedge clk);
      check("w0001_idle_valid", 32'(sv), 32'd0);
      check("w0001_idle_out", 32'(so), 32'd0);
      step();

      xfer(16'h8001, -1, -1, -1, c0, c1, cyc);
      check("w8001_lsb", 32'(c0), 32'h8001);
      check("w8001_msb", 32'(c1), 32'h8001);

      // Back-to-back: second word waits with load_valid high.
      load_valid = 1'b1;
      i = 16'hA5A5;
      guard = 0;
      @(negedge clk);
      while (!lr[0] && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      step();
      i = 16'h5A5A;
      b0 = '0; b1 = '0; n = 0; cyc = 0;
      while (n < 32 && cyc < 80) begin
         logic tk;
         @(negedge clk);
         tk = load_valid && lr[0];
         if (sv[0]) begin
            b0[n] = so[0];
            b1[n] = so[1];
            n++;
         end
         step();
         cyc++;
         if (tk) load_valid = 1'b0;
      end
      load_valid = 1'b0;
      check("b2b_cycles", 32'(cyc), 32'd32);
      check("b2b_lsb", b0, 32'h5A5AA5A5);
      check("b2b_msb", b1, 32'h5A5AA5A5);
      @(negedge clk);
      check("b2b_idle", 32'(sv), 32'd0);
      step();

      // Backpressure at cnt=7 for three cycles.
      xfer(16'hFF00, 7, -1, -1, c0, c1, cyc);
      check("bp_lsb", 32'(c0), 32'hFF00);
      check("bp_msb", 32'(c1), 32'h00FF);
      check("bp_cycles", 32'(cyc), 32'd19);

      // Reset mid-word at cnt=9.
      xfer(16'hFFFF, -1, 9, -1, c0, c1, cyc);
      @(negedge clk);
      check("mid_rst_valid", 32'(sv), 32'd0);
      check("mid_rst_busy", 32'(bsy), 32'd0);
      check("mid_rst_s_lsb", 32'(ss[0]), 32'd0);
      check("mid_rst_s_msb", 32'(ss[1]), 32'd15);
      check("mid_rst_ready", 32'(lr), 32'd3);
      step();
      xfer(16'h0000, -1, -1, -1, c0, c1, cyc);
      check("zero_lsb", 32'(c0), 32'h0000);
      check("zero_msb", 32'(c1), 32'h0000);

      // Stray load_valid pulse at cnt=4 must be ignored.
      xfer(16'h1234, -1, -1, 4, c0, c1, cyc);
      check("pulse_lsb", 32'(c0), 32'h1234);
      check("pulse_msb", 32'(c1), 32'h2C48);
      @(negedge clk);
      check("pulse_idle", 32'(sv), 32'd0);
      step();
      step();

      for (int k = 0; k < 2; k++)
         check($sformatf("stream_drained[%0d]", k), 32'(q_bits[k].size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
